feed_msg_sequencer: RTL and testbench

Sequences raw 32-bit message words from two independent market-feed sources into the nine-word register bank consumed by the order parser. Arbitrates round-robin between sources at message boundaries and assembles exactly nine words per message. Screens the message-type byte, then issues a single-cycle `o_data_valid` strobe with the register bank held stable. Sits between the feed input FIFOs and the parser, and is the only driver of the parser's register inputs and valid strobe.

---
 rtl/feed_msg_sequencer.sv | 169 ++++++++++++++++
 tb/tb_feed_msg_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_msg_sequencer.sv
// rtl/feed_msg_sequencer.sv - two-source round-robin sequencer assembling nine-word messages for the order parser
module feed_msg_sequencer #(
  parameter int REG_WIDTH      = 32,
  parameter int MSG_WORDS      = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_src0_valid,
  input  logic [REG_WIDTH-1:0] i_src0_word,
  output logic                 o_src0_ready,
  input  logic                 i_src1_valid,
  input  logic [REG_WIDTH-1:0] i_src1_word,
  output logic                 o_src1_ready,
  output logic [REG_WIDTH-1:0] o_reg_0,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic [REG_WIDTH-1:0] o_reg_8,
  output logic                 o_data_valid,
  output logic                 o_src_id,
  output logic                 o_busy,
  output logic [15:0]          o_msg_count,
  output logic [15:0]          o_drop_count
);

  localparam int IDX_W = $clog2(MSG_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 src_id_q, src_id_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [15:0]          msg_count_q, msg_count_d;
  logic [15:0]          drop_count_q, drop_count_d;
  logic [REG_WIDTH-1:0] bank_q [MSG_WORDS];
  logic                 bank_we;
  logic                 gnt_valid;
  logic [REG_WIDTH-1:0] gnt_word;
  logic [7:0]           msg_type;
  logic                 type_ok;

  assign gnt_valid = src_id_q ? i_src1_valid : i_src0_valid;
  assign gnt_word  = src_id_q ? i_src1_word  : i_src0_word;

  // The type byte normally comes from the banked word 0; a one-word message would screen the live word.
  assign msg_type = (idx_q == '0) ? gnt_word[7:0] : bank_q[0][7:0];
  assign type_ok  = (msg_type == 8'h41) || (msg_type == 8'h44) || (msg_type == 8'h45);

  // State, arbitration history, index, timeout and counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      src_id_q     <= 1'b0;
      idx_q        <= '0;
      tmo_q        <= '0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_id_q     <= src_id_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Register bank: written only by accepted words, kept across issue and drop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < MSG_WORDS; k++) begin
        bank_q[k] <= '0;
      end
    end else if (bank_we) begin
      bank_q[idx_q] <= gnt_word;
    end
  end

  // Next-state: round-robin grant in IDLE, word collection with type screen and timeout, one-cycle issue.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_id_d     = src_id_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;
    bank_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_src0_valid && (!i_src1_valid || last_grant_q)) begin
          src_id_d     = 1'b0;
          last_grant_d = 1'b0;
          idx_d        = '0;
          tmo_d        = '0;
          state_d      = COLLECT;
        end else if (i_src1_valid) begin
          src_id_d     = 1'b1;
          last_grant_d = 1'b1;
          idx_d        = '0;
          tmo_d        = '0;
          state_d      = COLLECT;
        end
      end
      COLLECT: begin
        if (gnt_valid) begin
          bank_we = 1'b1;
          tmo_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            if (type_ok) begin
              state_d     = ISSUE;
              msg_count_d = msg_count_q + 16'd1;
            end else begin
              state_d      = IDLE;
              drop_count_d = drop_count_q + 16'd1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = IDLE;
          drop_count_d = drop_count_q + 16'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_src0_ready = (state_q == COLLECT) && !src_id_q;
  assign o_src1_ready = (state_q == COLLECT) && src_id_q;
  assign o_data_valid = (state_q == ISSUE);
  assign o_busy       = (state_q != IDLE);
  assign o_src_id     = src_id_q;
  assign o_msg_count  = msg_count_q;
  assign o_drop_count = drop_count_q;

  assign o_reg_0 = bank_q[0];
  assign o_reg_1 = bank_q[1];
  assign o_reg_2 = bank_q[2];
  assign o_reg_3 = bank_q[3];
  assign o_reg_4 = bank_q[4];
  assign o_reg_5 = bank_q[5];
  assign o_reg_6 = bank_q[6];
  assign o_reg_7 = bank_q[7];
  assign o_reg_8 = bank_q[8];

endmodule

// File: tb/tb_feed_msg_sequencer.sv
// tb/tb_feed_msg_sequencer.sv - self-checking bench for feed_msg_sequencer
module tb_feed_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        src0_valid = 1'b0;
  logic [31:0] src0_word = '0;
  logic        src0_ready;
  logic        src1_valid = 1'b0;
  logic [31:0] src1_word = '0;
  logic        src1_ready;
  logic [31:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8;
  logic        data_valid, src_id, busy;
  logic [15:0] msg_count, drop_count;

  always #5 clk = ~clk;

  feed_msg_sequencer dut (
    .i_clk(clk), .i_reset(rst),
    .i_src0_valid(src0_valid), .i_src0_word(src0_word), .o_src0_ready(src0_ready),
    .i_src1_valid(src1_valid), .i_src1_word(src1_word), .o_src1_ready(src1_ready),
    .o_reg_0(reg0), .o_reg_1(reg1), .o_reg_2(reg2), .o_reg_3(reg3), .o_reg_4(reg4),
    .o_reg_5(reg5), .o_reg_6(reg6), .o_reg_7(reg7), .o_reg_8(reg8),
    .o_data_valid(data_valid), .o_src_id(src_id), .o_busy(busy),
    .o_msg_count(msg_count), .o_drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model: per-source word queues, messages completed in order of acceptance
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];
  logic [31:0] cur [2][9];
  int          cnt [2];
  logic [15:0] exp_msg, exp_drop;
  logic        pend;
  logic        pend_src;
  logic [31:0] pend_msg [9];
  int          done_src[$];
  int          strobe_cyc[$];
  int          strobes = 0;
  int          cyc = 0;

  typedef struct {
    logic        v0;
    logic [31:0] w0;
    logic        r0;
    logic        r1;
    logic        busy;
    logic        dv;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int k);
    case (k)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      3: return reg3;
      4: return reg4;
      5: return reg5;
      6: return reg6;
      7: return reg7;
      default: return reg8;
    endcase
  endfunction

  function automatic bit good_type(input logic [7:0] t);
    return (t == 8'h41) || (t == 8'h44) || (t == 8'h45);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    wq0.delete();
    wq1.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    exp_msg = '0;
    exp_drop = '0;
    pend = 1'b0;
    done_src.delete();
    strobe_cyc.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_msg(input int src, input logic [31:0] word0);
    logic [31:0] r;
    for (int k = 0; k < 9; k++) begin
      r = (k == 0) ? word0 : $urandom();
      if (src == 0) wq0.push_back(r);
      else wq1.push_back(r);
    end
  endtask

  task automatic accept(input int src, input logic [31:0] w);
    if (src == 0) void'(wq0.pop_front());
    else void'(wq1.pop_front());
    cur[src][cnt[src]] = w;
    cnt[src]++;
    if (cnt[src] == 9) begin
      cnt[src] = 0;
      done_src.push_back(src);
      if (good_type(cur[src][0][7:0])) begin
        pend = 1'b1;
        pend_src = (src == 1);
        for (int k = 0; k < 9; k++) pend_msg[k] = cur[src][k];
        exp_msg++;
      end else begin
        exp_drop++;
      end
    end
  endtask

  // one clock cycle: drive sources from the model queues, compare outputs, advance the model
  task automatic tick(input bit en0, input bit en1);
    logic a0, a1;
    cyc++;
    src0_valid = en0 && (wq0.size() > 0);
    src0_word  = src0_valid ? wq0[0] : $urandom();
    src1_valid = en1 && (wq1.size() > 0);
    src1_word  = src1_valid ? wq1[0] : $urandom();
    chk("strobe", data_valid, pend);
    if (data_valid) begin
      strobes++;
      strobe_cyc.push_back(cyc);
    end
    if (pend && data_valid) begin
      chk("src_id", src_id, pend_src);
      for (int k = 0; k < 9; k++) chk($sformatf("reg%0d", k), get_reg(k), pend_msg[k]);
    end
    chk("msg_count", msg_count, exp_msg);
    chk("drop_count", drop_count, exp_drop);
    chk("one_ready", src0_ready && src1_ready, 1'b0);
    a0 = src0_valid && src0_ready;
    a1 = src1_valid && src1_ready;
    step();
    pend = 1'b0;
    if (a0) accept(0, src0_word);
    if (a1) accept(1, src1_word);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, s_before, run0, run1;
    bit en0, en1;
    int exp_order [4];
    logic [31:0] m [9];
    logic [7:0] bad_t [5];
    logic [7:0] good_t [3];

    exp_order = '{0, 1, 0, 1};
    bad_t  = '{8'h00, 8'h42, 8'h58, 8'hFF, 8'h46};
    good_t = '{8'h41, 8'h44, 8'h45};

    // single add message, cycle by cycle
    m[0] = 32'h0000_0141;
    for (int k = 1; k < 8; k++) m[k] = 32'h1000_0000 + k;
    m[8] = 32'h0000_0064;
    tbl[0] = '{1'b1, m[0], 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 9; k++) tbl[k+1] = '{1'b1, m[k], 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    model_clear();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_ready", {src0_ready, src1_ready}, 0);
    chk("rst_counts", {msg_count, drop_count}, 0);
    chk("rst_reg0", reg0, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      src0_valid = tbl[i].v0;
      src0_word  = tbl[i].w0;
      chk($sformatf("tbl%0d_r0", i), src0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_r1", i), src1_ready, tbl[i].r1);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_dv", i), data_valid, tbl[i].dv);
      step();
    end
    chk("add_reg0", reg0, 32'h0000_0141);
    chk("add_reg8", reg8, 32'h0000_0064);
    chk("add_src", src_id, 0);
    chk("add_msgcnt", msg_count, 1);

    // contention: both sources hold valid with two delete messages each
    do_reset();
    push_msg(0, 32'h0000_0044); push_msg(0, 32'h0100_0044);
    push_msg(1, 32'h0200_0044); push_msg(1, 32'h0300_0044);
    repeat (44) tick(1, 1);
    chk("cont_msgcnt", msg_count, 4);
    chk("cont_n", done_src.size(), 4);
    chk("cont_strobes", strobe_cyc.size(), 4);
    for (int i = 0; i < done_src.size() && i < 4; i++) chk("cont_order", done_src[i], exp_order[i]);
    for (int i = 0; i < strobe_cyc.size() && i < 4; i++) chk("cont_cycle", strobe_cyc[i], 11 * (i + 1));

    // bad type from source 1
    do_reset();
    push_msg(1, 32'h0000_0058);
    g = 0;
    while (wq1.size() > 0 && g < 40) begin tick(0, 1); g++; end
    chk("bad_drain", wq1.size(), 0);
    chk("bad_busy", busy, 0);
    chk("bad_dv", data_valid, 0);
    chk("bad_drop", drop_count, 1);
    chk("bad_msg", msg_count, 0);
    tick(0, 0);

    // timeout after four words, then a fresh message from source 1
    do_reset();
    push_msg(0, 32'h0000_0041);
    g = 0;
    while (cnt[0] < 4 && g < 40) begin tick(1, 0); g++; end
    chk("to_partial", cnt[0], 4);
    repeat (15) tick(0, 0);
    chk("to_busy15", busy, 1);
    tick(0, 0);
    exp_drop++;
    cnt[0] = 0;
    wq0.delete();
    chk("to_busy", busy, 0);
    chk("to_drop", drop_count, 1);
    s_before = strobes;
    push_msg(1, 32'h0000_0044);
    g = 0;
    while (wq1.size() > 0 && g < 40) begin tick(0, 1); g++; end
    tick(0, 0);
    tick(0, 0);
    chk("to_fresh", strobes - s_before, 1);
    chk("to_msg", msg_count, 1);

    // stall of 15 idle cycles between words 3 and 4
    do_reset();
    s_before = strobes;
    push_msg(0, 32'h0000_0045);
    g = 0;
    while (cnt[0] < 4 && g < 40) begin tick(1, 0); g++; end
    repeat (15) tick(0, 0);
    g = 0;
    while (wq0.size() > 0 && g < 40) begin tick(1, 0); g++; end
    tick(0, 0);
    tick(0, 0);
    chk("stall_strobes", strobes - s_before, 1);
    chk("stall_drop", drop_count, 0);

    // asynchronous reset in the middle of a second message
    do_reset();
    push_msg(0, 32'h0000_0041);
    push_msg(0, 32'h0000_0045);
    g = 0;
    while (!(done_src.size() == 1 && cnt[0] == 6) && g < 60) begin tick(1, 0); g++; end
    chk("ar_before", msg_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", {src0_ready, src1_ready}, 0);
    chk("ar_counts", {msg_count, drop_count}, 0);
    chk("ar_reg0", reg0, 0);
    chk("ar_reg5", reg5, 0);
    chk("ar_src", src_id, 0);
    chk("ar_dv", data_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    push_msg(0, 32'h0000_0044);
    push_msg(1, 32'h0000_0045);
    g = 0;
    while (done_src.size() < 1 && g < 40) begin tick(1, 1); g++; end
    chk("ar_n", done_src.size(), 1);
    if (done_src.size() > 0) chk("ar_first", done_src[0], 0);
    g = 0;
    while ((wq0.size() > 0 || wq1.size() > 0) && g < 40) begin tick(1, 1); g++; end
    tick(0, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 3) == 3) push_msg(s, {$urandom_range(0, 65535), 8'h00, bad_t[$urandom_range(0, 4)]});
        else push_msg(s, {$urandom_range(0, 65535), 8'h00, good_t[$urandom_range(0, 2)]});
      end
    end
    run0 = 0;
    run1 = 0;
    g = 0;
    while ((wq0.size() > 0 || wq1.size() > 0) && g < 5000) begin
      en0 = ($urandom_range(0, 99) < 65) || (run0 >= 10);
      en1 = ($urandom_range(0, 99) < 65) || (run1 >= 10);
      if (en0) run0 = 0; else if (wq0.size() > 0) run0++;
      if (en1) run1 = 0; else if (wq1.size() > 0) run1++;
      tick(en0, en1);
      g++;
    end
    chk("rand_drain", wq0.size() + wq1.size(), 0);
    tick(0, 0);
    tick(0, 0);
    chk("rand_total", msg_count + drop_count, 24);
    chk("rand_msg", msg_count, exp_msg);
    chk("rand_drop", drop_count, exp_drop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
